// File: rtl/nios_ii_system_button_pio.sv
// Avalon-MM button/switch PIO: per-channel synchroniser and debouncer, edge capture
// with write-one-to-clear, a masked level interrupt and a 16-bit event counter.
module nios_ii_system_button_pio_chan #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic sync,
  output logic db,
  output logic db_dly
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d, db_dly_q, db_dly_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_raw};
    cnt_d    = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    // Count only while the synchronised level disagrees; the Nth disagreeing cycle commits it.
    if (sync_q[SYNC_STAGES-1] != db_q) begin
      if (cnt_q == CNT_LAST) db_d = sync_q[SYNC_STAGES-1];
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign db     = db_q;
  assign db_dly = db_dly_q;
endmodule

module nios_ii_system_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync_w, db_w, db_dly_w, rise, fall, set_evt;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d, edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [15:0]      evt_cnt_q, evt_cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    nios_ii_system_button_pio_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .in_raw(in_port[i]),
      .sync  (sync_w[i]),
      .db    (db_w[i]),
      .db_dly(db_dly_w[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign rise         = db_w & ~db_dly_w;
  assign fall         = ~db_w & db_dly_w;
  assign set_evt      = (rise & rise_en_q) | (fall & fall_en_q);
  assign unused_wdata = ^writedata;

  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    edge_cap_d = edge_cap_q;
    evt_cnt_d  = evt_cnt_q;
    if (wr_en) begin
      case (address)
        3'd2:    irq_mask_d = writedata[WIDTH-1:0];
        3'd3:    edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        3'd4:    rise_en_d  = writedata[WIDTH-1:0];
        3'd5:    fall_en_d  = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    // Set is applied after the clear so a same-cycle event is never lost.
    edge_cap_d = edge_cap_d | set_evt;
    if (wr_en && address == 3'd6) evt_cnt_d = '0;
    else if (|set_evt)            evt_cnt_d = evt_cnt_q + 16'd1;

    readdata_d = '0;
    case (address)
      3'd0:    readdata_d[WIDTH-1:0] = db_w;
      3'd1:    readdata_d[WIDTH-1:0] = sync_w;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
      3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
      3'd6:    readdata_d[15:0]      = evt_cnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      edge_cap_q <= '0;
      evt_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      edge_cap_q <= edge_cap_d;
      evt_cnt_q  <= evt_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);
endmodule

// File: tb/tb_nios_ii_system_button_pio.sv
// Bench for the button PIO: register table, hand-timed corner cases, random debounce
// traffic against a window model, and a DEBOUNCE_CYCLES=1 instance for counter wrap.
module tb_nios_ii_system_button_pio;
  localparam int DB = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  address, f_address;
  logic        chipselect, write_n, f_cs, f_wn;
  logic [31:0] writedata, f_wdata, readdata, f_readdata;
  logic [3:0]  in_port, f_in;
  logic        irq, f_irq;

  int checks = 0;
  int failures = 0;

  nios_ii_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq));

  nios_ii_system_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) u_fast (
    .clk(clk), .reset(reset), .address(f_address), .chipselect(f_cs), .write_n(f_wn),
    .writedata(f_wdata), .in_port(f_in), .readdata(f_readdata), .irq(f_irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    bit          do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit f, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    if (f) begin f_address = a; f_wdata = d; f_cs = 1'b1; f_wn = 1'b0; end
    else begin address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; end
    @(negedge clk);
    f_cs = 1'b0; f_wn = 1'b1; chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input bit f, input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    if (f) f_address = a; else address = a;
    @(negedge clk);
    check(nm, f ? f_readdata : readdata, exp);
  endtask

  // Random-phase reference: in_port value applied at each clock edge, and accepted levels.
  logic [3:0] inq[$];
  logic [3:0] db_m, cap_m, rd_exp, cur, flip;
  int         evt_m, hold;
  bit         all_diff;

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
    f_address = '0; f_cs = 1'b0; f_wn = 1'b1; f_wdata = '0; f_in = '0;
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;

    tbl[0]  = '{3'd0, 1'b0, 32'h0,        32'h0, "rst_db"};
    tbl[1]  = '{3'd1, 1'b0, 32'h0,        32'h0, "rst_sync"};
    tbl[2]  = '{3'd2, 1'b0, 32'h0,        32'h0, "rst_mask"};
    tbl[3]  = '{3'd3, 1'b0, 32'h0,        32'h0, "rst_cap"};
    tbl[4]  = '{3'd4, 1'b0, 32'h0,        32'h0, "rst_rise_en"};
    tbl[5]  = '{3'd5, 1'b0, 32'h0,        32'hF, "rst_fall_en"};
    tbl[6]  = '{3'd6, 1'b0, 32'h0,        32'h0, "rst_evt"};
    tbl[7]  = '{3'd7, 1'b0, 32'h0,        32'h0, "rst_a7"};
    tbl[8]  = '{3'd2, 1'b1, 32'hFFFFFFF5, 32'h5, "mask_rw"};
    tbl[9]  = '{3'd4, 1'b1, 32'hA,        32'hA, "rise_en_rw"};
    tbl[10] = '{3'd5, 1'b1, 32'h3,        32'h3, "fall_en_rw"};
    tbl[11] = '{3'd0, 1'b1, 32'hF,        32'h0, "db_ro"};
    tbl[12] = '{3'd1, 1'b1, 32'hF,        32'h0, "sync_ro"};
    tbl[13] = '{3'd7, 1'b1, 32'hFFFFFFFF, 32'h0, "a7_zero"};
    tbl[14] = '{3'd2, 1'b1, 32'h0,        32'h0, "mask_clr"};
    tbl[15] = '{3'd4, 1'b1, 32'h0,        32'h0, "rise_en_clr"};
    tbl[16] = '{3'd5, 1'b1, 32'hFFFFFFFF, 32'hF, "fall_en_restore"};
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].do_wr) wr(1'b0, tbl[i].addr, tbl[i].wdata);
      rd_chk(1'b0, tbl[i].addr, tbl[i].exp, tbl[i].nm);
    end

    // Write strobe without chipselect must be ignored.
    @(negedge clk); address = 3'd2; writedata = 32'hF; write_n = 1'b0;
    @(negedge clk); write_n = 1'b1;
    rd_chk(1'b0, 3'd2, 32'h0, "no_cs_write");

    // All inputs rise: readdata@0 still 0 after 6 edges, 0xF after 7.
    address = 3'd0; tick(2);
    in_port = 4'hF;
    tick(6); check("db_rise_early", readdata, 32'h0);
    tick(1); check("db_rise_6cyc", readdata, 32'hF);
    rd_chk(1'b0, 3'd3, 32'h0, "rise_not_captured");

    // 3-cycle glitch is filtered; 4-cycle glitch is accepted and captured.
    in_port = 4'hE; tick(3); in_port = 4'hF; tick(10);
    rd_chk(1'b0, 3'd0, 32'hF, "glitch3_db");
    rd_chk(1'b0, 3'd3, 32'h0, "glitch3_cap");
    address = 3'd0; tick(1);
    in_port = 4'hE; tick(4); in_port = 4'hF; tick(4);
    check("glitch4_db", readdata, 32'hE);
    tick(10);
    rd_chk(1'b0, 3'd3, 32'h1, "glitch4_cap");
    rd_chk(1'b0, 3'd6, 32'h1, "glitch4_evt");

    // Masked interrupt and write-one-to-clear.
    check("irq_unmasked", {31'h0, irq}, 32'h0);
    wr(1'b0, 3'd2, 32'h1);
    check("irq_masked_on", {31'h0, irq}, 32'h1);
    wr(1'b0, 3'd3, 32'h0);
    check("w1c_zero_irq", {31'h0, irq}, 32'h1);
    rd_chk(1'b0, 3'd3, 32'h1, "w1c_zero_cap");
    wr(1'b0, 3'd3, 32'h1);
    check("w1c_irq_low", {31'h0, irq}, 32'h0);
    rd_chk(1'b0, 3'd3, 32'h0, "w1c_cap");

    // Clear of bit1 lands in the cycle its fall edge sets: set must win.
    tick(1); in_port = 4'hD; tick(6);
    address = 3'd3; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
    tick(1); chipselect = 1'b0; write_n = 1'b1;
    rd_chk(1'b0, 3'd3, 32'h2, "set_beats_clr");
    rd_chk(1'b0, 3'd6, 32'h2, "set_beats_clr_evt");
    wr(1'b0, 3'd3, 32'h2);
    rd_chk(1'b0, 3'd3, 32'h0, "late_clr");
    in_port = 4'hF; tick(10);

    // Both edge directions enabled on bit2 only.
    wr(1'b0, 3'd4, 32'h4); wr(1'b0, 3'd5, 32'h4); wr(1'b0, 3'd3, 32'hF); wr(1'b0, 3'd6, 32'h0);
    in_port = 4'hB; tick(10);
    rd_chk(1'b0, 3'd3, 32'h4, "bit2_fall");
    wr(1'b0, 3'd3, 32'h4);
    in_port = 4'hF; tick(10);
    rd_chk(1'b0, 3'd3, 32'h4, "bit2_rise");
    wr(1'b0, 3'd3, 32'h4);
    in_port = 4'hE; tick(10); in_port = 4'hF; tick(10);
    rd_chk(1'b0, 3'd3, 32'h0, "bit0_disabled");
    rd_chk(1'b0, 3'd6, 32'h2, "bit2_evt");

    // Reset mid-debounce with irq active.
    wr(1'b0, 3'd2, 32'hF); wr(1'b0, 3'd5, 32'hF);
    in_port = 4'hE; tick(10);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    in_port = 4'h0; tick(3);
    reset = 1'b1; #1;
    check("async_rst_rd", readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    tick(3); reset = 1'b0; tick(10);
    rd_chk(1'b0, 3'd0, 32'h0, "post_rst_db");
    rd_chk(1'b0, 3'd3, 32'h0, "post_rst_cap");
    rd_chk(1'b0, 3'd6, 32'h0, "post_rst_evt");
    rd_chk(1'b0, 3'd2, 32'h0, "post_rst_mask");
    rd_chk(1'b0, 3'd4, 32'h0, "post_rst_rise_en");
    rd_chk(1'b0, 3'd5, 32'hF, "post_rst_fall_en");
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    // Random traffic: a level is accepted once the last DB synchronised samples all oppose it.
    wr(1'b0, 3'd4, 32'hF);
    for (int j = 0; j < DB + 2; j++) inq.push_back(4'h0);
    db_m = '0; cap_m = '0; evt_m = 0; cur = '0; hold = 0; rd_exp = '0;
    address = 3'd0; tick(1);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      check("rand_db", readdata, {28'h0, rd_exp});
      if (k < 560) begin
        if (hold == 0) begin cur = 4'($urandom); hold = $urandom_range(1, 7); end
        hold--;
      end
      in_port = cur;
      inq.push_back(cur);
      rd_exp = db_m;
      flip = '0;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (inq[inq.size() - 1 - j][i] == db_m[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
      db_m  = db_m ^ flip;
      cap_m = cap_m | flip;
      if (flip != 4'h0) evt_m++;
    end
    rd_chk(1'b0, 3'd3, {28'h0, cap_m}, "rand_cap");
    rd_chk(1'b0, 3'd6, {16'h0, 16'(evt_m)}, "rand_evt");

    // DEBOUNCE_CYCLES=1: db follows sync one cycle later.
    f_address = 3'd0; tick(2);
    f_in = 4'h1; tick(3);
    check("fast_db_early", f_readdata, 32'h0);
    tick(1);
    check("fast_db_follow", f_readdata, 32'h1);

    // Every in_port toggle is one event cycle; 65536 of them wrap the counter.
    wr(1'b1, 3'd4, 32'h1); wr(1'b1, 3'd6, 32'h0);
    for (int t = 0; t < 65535; t++) begin
      @(negedge clk); f_in = f_in ^ 4'h1;
    end
    tick(6);
    rd_chk(1'b1, 3'd6, 32'hFFFF, "evt_ffff");
    f_in = f_in ^ 4'h1; tick(6);
    rd_chk(1'b1, 3'd6, 32'h0, "evt_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
